iic_byte_master: RTL and testbench

Single-byte I2C master that performs one register write or one register read per request.
Each transaction carries a 7-bit device address and an 8-bit register address.
It sits directly downstream of the global reset generator and takes the generated synchronous reset as its only reset.
It drives the board I2C pins through open-drain SDA control and a push-pull SCL.

---
 rtl/iic_byte_master_pkg.sv | 38 +++
 rtl/iic_qtick.sv | 39 +++
 rtl/iic_byte_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_iic_byte_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_byte_master_pkg.sv
// rtl/iic_byte_master_pkg.sv - shared encodings for the single-byte I2C master
// Holds the FSM state encoding, the quarter-phase codes, the rw encoding and
// the quarter-bit divider calculation. No ports.
package iic_byte_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_DEV_W,
        ST_ACK_DW,
        ST_REG,
        ST_ACK_REG,
        ST_WDATA,
        ST_ACK_WD,
        ST_RESTART,
        ST_DEV_R,
        ST_ACK_DR,
        ST_RDATA,
        ST_MNACK,
        ST_STOP
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Clocks per quarter of an SCL period, floored, never below one.
    function automatic int calc_div(input int clk_freq, input int iic_freq);
        int d;
        d = clk_freq / (4 * iic_freq);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/iic_qtick.sv
// rtl/iic_qtick.sv - quarter-bit tick generator for the I2C master
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : counter runs while high, is held cleared while low
//   tick     : one-cycle pulse on the last clock of each quarter
//   phase    : current quarter (Q0..Q3) within the bit
module iic_qtick
    import iic_byte_master_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CNT_MAX);

    // Clearing on !en makes every transaction start at the top of Q0.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt   <= '0;
            phase <= Q0;
        end else if (tick) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/iic_byte_master.sv
// rtl/iic_byte_master.sv - single-byte I2C master, one register write or read per request
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start           : request pulse, accepted only while idle
//   rw              : 0 register write, 1 register read
//   dev_addr        : 7-bit slave address
//   reg_addr        : 8-bit register address
//   wr_data         : write payload
//   rd_data         : last byte read back
//   busy            : transaction in progress
//   done            : one-cycle pulse when STOP completes
//   ack_err         : a NACK was seen in the last transaction
//   scl_o           : push-pull SCL drive
//   sda_oe          : 1 pulls SDA low, 0 releases it
//   sda_i           : SDA pin sample
module iic_byte_master
    import iic_byte_master_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int IIC_FREQ = 400_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int DIV = calc_div(CLK_FREQ, IIC_FREQ);

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] tx_sr, tx_n;
    logic [7:0] rx_sr, rx_n;
    logic       nack_q, nack_n;
    logic [7:0] rd_data_n;
    logic       ack_err_n;
    logic       done_n;
    logic       capture;
    logic       scl_d, oe_d;

    logic       lat_rw;
    logic [6:0] lat_dev;
    logic [7:0] lat_reg;
    logic [7:0] lat_wd;

    logic       tick;
    logic [1:0] phase;
    logic       scl_mid;

    assign busy    = (state != ST_IDLE);
    assign scl_mid = (phase == Q1) || (phase == Q2);

    iic_qtick #(
        .DIV (DIV)
    ) u_qtick (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .tick  (tick),
        .phase (phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
            tx_sr   <= 8'd0;
            rx_sr   <= 8'd0;
            nack_q  <= 1'b0;
            rd_data <= 8'd0;
            ack_err <= 1'b0;
            done    <= 1'b0;
            scl_o   <= 1'b1;
            sda_oe  <= 1'b0;
            lat_rw  <= RW_WRITE;
            lat_dev <= 7'd0;
            lat_reg <= 8'd0;
            lat_wd  <= 8'd0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_n;
            tx_sr   <= tx_n;
            rx_sr   <= rx_n;
            nack_q  <= nack_n;
            rd_data <= rd_data_n;
            ack_err <= ack_err_n;
            done    <= done_n;
            // Pins are retimed from the decoded quarter so SCL/SDA never glitch.
            scl_o   <= scl_d;
            sda_oe  <= oe_d;
            if (capture) begin
                lat_rw  <= rw;
                lat_dev <= dev_addr;
                lat_reg <= reg_addr;
                lat_wd  <= wr_data;
            end
        end
    end

    // Sampling happens on the Q2 tick, state changes on the Q3 tick, so every
    // state occupies a whole number of bits.
    always_comb begin
        state_n   = state;
        bit_n     = bit_cnt;
        tx_n      = tx_sr;
        rx_n      = rx_sr;
        nack_n    = nack_q;
        rd_data_n = rd_data;
        ack_err_n = ack_err;
        done_n    = 1'b0;
        capture   = 1'b0;

        if (state == ST_IDLE) begin
            if (start) begin
                capture   = 1'b1;
                ack_err_n = 1'b0;
                bit_n     = 3'd0;
                state_n   = ST_START;
            end
        end else if (tick) begin
            if (phase == Q2) begin
                case (state)
                    ST_RDATA:                                 rx_n   = {rx_sr[6:0], sda_i};
                    ST_ACK_DW, ST_ACK_REG, ST_ACK_WD, ST_ACK_DR: nack_n = sda_i;
                    default:                                  ;
                endcase
            end
            if (phase == Q3) begin
                case (state)
                    ST_START: begin
                        state_n = ST_DEV_W;
                        tx_n    = {lat_dev, 1'b0};
                    end
                    ST_DEV_W, ST_REG, ST_WDATA, ST_DEV_R: begin
                        tx_n  = {tx_sr[6:0], 1'b0};
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                ST_DEV_W: state_n = ST_ACK_DW;
                                ST_REG:   state_n = ST_ACK_REG;
                                ST_WDATA: state_n = ST_ACK_WD;
                                default:  state_n = ST_ACK_DR;
                            endcase
                        end
                    end
                    ST_ACK_DW: begin
                        if (nack_q) begin
                            ack_err_n = 1'b1;
                            state_n   = ST_STOP;
                        end else begin
                            state_n = ST_REG;
                            tx_n    = lat_reg;
                        end
                    end
                    ST_ACK_REG: begin
                        if (nack_q) begin
                            ack_err_n = 1'b1;
                            state_n   = ST_STOP;
                        end else if (lat_rw == RW_READ) begin
                            state_n = ST_RESTART;
                        end else begin
                            state_n = ST_WDATA;
                            tx_n    = lat_wd;
                        end
                    end
                    ST_ACK_WD: begin
                        if (nack_q) ack_err_n = 1'b1;
                        state_n = ST_STOP;
                    end
                    ST_RESTART: begin
                        state_n = ST_DEV_R;
                        tx_n    = {lat_dev, 1'b1};
                    end
                    ST_ACK_DR: begin
                        if (nack_q) begin
                            ack_err_n = 1'b1;
                            state_n   = ST_STOP;
                        end else begin
                            state_n = ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        bit_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_n = ST_MNACK;
                    end
                    ST_MNACK: begin
                        // Only a fully received, acknowledged read updates rd_data.
                        rd_data_n = rx_sr;
                        state_n   = ST_STOP;
                    end
                    ST_STOP: begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    // Pin waveform per quarter of the current state.
    always_comb begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state)
            ST_START: begin
                scl_d = (phase != Q3);
                oe_d  = (phase == Q2) || (phase == Q3);
            end
            ST_RESTART: begin
                // SDA already released by the preceding ACK bit; SCL rises in Q1.
                scl_d = scl_mid;
                oe_d  = (phase == Q2) || (phase == Q3);
            end
            ST_STOP: begin
                scl_d = (phase != Q0);
                oe_d  = (phase != Q3);
            end
            ST_DEV_W, ST_REG, ST_WDATA, ST_DEV_R: begin
                scl_d = scl_mid;
                oe_d  = ~tx_sr[7];
            end
            ST_ACK_DW, ST_ACK_REG, ST_ACK_WD, ST_ACK_DR, ST_RDATA, ST_MNACK: begin
                scl_d = scl_mid;
                oe_d  = 1'b0;
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_iic_byte_master.sv
// tb/tb_iic_byte_master.sv - self-checking bench for iic_byte_master with an I2C slave model
module tb_iic_byte_master;

    localparam int CLK_FREQ = 50_000_000;
    localparam int IIC_FREQ = 400_000;
    localparam int DIV_TB   = CLK_FREQ / (4 * IIC_FREQ);
    localparam int EV_S     = 256;
    localparam int EV_P     = 257;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] rd_data;
    logic       busy, done, ack_err, scl_o, sda_oe;
    logic       sda_bus;

    int checks = 0;
    int errors = 0;

    // slave model state
    bit         sl_pull = 1'b0;
    int         sl_nack_at = -1;
    bit [7:0]   sl_rdv = 8'h00;
    int         txn_id = 0;
    int         sl_id = 0;
    int         sl_bits = 0;
    int         sl_byte_no = 0;
    bit [7:0]   sl_byte = 8'h00;
    bit [7:0]   sl_sh = 8'h00;
    bit         sl_first = 1'b0;
    bit         sl_tx = 1'b0;
    bit         sl_rd_addr = 1'b0;
    bit         p_scl = 1'b1;
    bit         p_sda = 1'b1;
    int         bus_log[$];

    assign sda_bus = !(sda_oe || sl_pull);

    always #5 clk = ~clk;

    iic_byte_master #(
        .CLK_FREQ (CLK_FREQ),
        .IIC_FREQ (IIC_FREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rw       (rw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl_o    (scl_o),
        .sda_oe   (sda_oe),
        .sda_i    (sda_bus)
    );

    // Protocol-level slave: logs START/STOP and every byte seen on the bus,
    // ACKs master bytes unless told to NACK one, and returns sl_rdv on reads.
    always @(negedge clk) begin
        bit scl_s, sda_s;
        scl_s = scl_o;
        sda_s = sda_bus;
        if (txn_id != sl_id) begin
            sl_id      = txn_id;
            sl_byte_no = 0;
            sl_bits    = 0;
            sl_tx      = 1'b0;
            sl_pull    = 1'b0;
        end else if (p_scl && scl_s && p_sda && !sda_s) begin
            bus_log.push_back(EV_S);
            sl_bits  = 0;
            sl_first = 1'b1;
            sl_tx    = 1'b0;
            sl_pull  = 1'b0;
        end else if (p_scl && scl_s && !p_sda && sda_s) begin
            bus_log.push_back(EV_P);
            sl_bits = 0;
            sl_tx   = 1'b0;
            sl_pull = 1'b0;
        end else if (!p_scl && scl_s) begin
            if (sl_bits < 8) sl_byte = {sl_byte[6:0], sda_s};
            sl_bits++;
        end else if (p_scl && !scl_s) begin
            if (sl_bits == 8) begin
                bus_log.push_back(int'(sl_byte));
                if (sl_tx) begin
                    sl_pull = 1'b0;
                end else begin
                    sl_pull    = (sl_byte_no != sl_nack_at);
                    sl_rd_addr = sl_first && sl_byte[0];
                    sl_byte_no++;
                end
                sl_first = 1'b0;
            end else if (sl_bits == 9) begin
                sl_bits = 0;
                if (sl_pull && sl_rd_addr) begin
                    sl_tx = 1'b1;
                    sl_sh = sl_rdv;
                end else begin
                    sl_tx = 1'b0;
                end
                sl_rd_addr = 1'b0;
                sl_pull    = sl_tx ? !sl_sh[7] : 1'b0;
            end else if (sl_tx && sl_bits >= 1 && sl_bits <= 7) begin
                sl_pull = !sl_sh[7 - sl_bits];
            end
        end
        p_scl = scl_s;
        p_sda = sda_s;
    end

    typedef struct {
        bit             rw;
        bit [6:0]       dev;
        bit [7:0]       rg;
        bit [7:0]       wd;
        bit [7:0]       rdv;
        int             nack_at;
        int             exp_cyc;
        bit             exp_err;
        bit [7:0]       exp_rd;
        int             ev_n;
        logic [7:0][8:0] ev;
    } vec_t;

    // Reference: the transaction as a list of bus segments, in quarters:
    // START/RESTART/STOP 4, each byte with its ACK 36.
    function automatic vec_t mk(input bit rw_i, input bit [6:0] dv, input bit [7:0] rg,
                                input bit [7:0] wd, input bit [7:0] rdv, input int nk,
                                input bit [7:0] prev_rd);
        vec_t v;
        int   q;
        int   e;
        v.rw = rw_i; v.dev = dv; v.rg = rg; v.wd = wd; v.rdv = rdv; v.nack_at = nk;
        v.ev = '0;
        q = 4;
        e = 0;
        v.ev[e] = 9'(EV_S); e++;
        for (int i = 0; i < 3; i++) begin
            if (rw_i && i == 2) begin
                q += 4;
                v.ev[e] = 9'(EV_S); e++;
            end
            q += 36;
            v.ev[e] = (i == 0) ? {1'b0, dv, 1'b0} :
                      (i == 1) ? {1'b0, rg} :
                      rw_i     ? {1'b0, dv, 1'b1} : {1'b0, wd};
            e++;
            if (nk == i) break;
        end
        if (rw_i && nk < 0) begin
            q += 36;
            v.ev[e] = {1'b0, rdv}; e++;
        end
        q += 4;
        v.ev[e] = 9'(EV_P); e++;
        v.ev_n    = e;
        v.exp_cyc = q * DIV_TB;
        v.exp_err = (nk >= 0);
        v.exp_rd  = (rw_i && nk < 0) ? rdv : prev_rd;
        return v;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int poke_at, input int rst_at);
        int n;
        int base;
        int dcount;
        bit seen;
        bit aborted;
        txn_id++;
        sl_rdv     = v.rdv;
        sl_nack_at = v.nack_at;
        repeat (3) @(negedge clk);
        base = bus_log.size();
        rw = v.rw; dev_addr = v.dev; reg_addr = v.rg; wr_data = v.wd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_capture", busy, 1);
        check("ack_err_cleared", ack_err, 0);
        n = 0; seen = 1'b0; aborted = 1'b0;
        while (n < v.exp_cyc + 50 && !seen && !aborted) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else if (n == poke_at) begin
                rw = ~v.rw; dev_addr = ~v.dev; reg_addr = ~v.rg; wr_data = ~v.wd;
                start = 1'b1;
            end else if (n == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check("rst_mid_scl", scl_o, 1);
                check("rst_mid_sda_oe", sda_oe, 0);
                check("rst_mid_busy", busy, 0);
                check("rst_mid_done", done, 0);
                check("rst_mid_rd_data", rd_data, 0);
                aborted = 1'b1;
            end
        end
        if (aborted) begin
            dcount = 0;
            repeat (200) begin
                @(posedge clk); #1;
                if (done) dcount++;
            end
            check("no_done_after_rst", dcount, 0);
        end else begin
            check("done_seen", seen, 1);
            check("done_latency", (n == v.exp_cyc + 1) ? v.exp_cyc : n, v.exp_cyc);
            check("busy_low_at_done", busy, 0);
            check("ack_err", ack_err, int'(v.exp_err));
            check("rd_data", rd_data, int'(v.exp_rd));
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
            check("idle_scl", scl_o, 1);
            check("idle_sda_oe", sda_oe, 0);
            check("ev_count", bus_log.size() - base, v.ev_n);
            for (int i = 0; i < v.ev_n; i++) begin
                check($sformatf("ev%0d", i),
                      (base + i < bus_log.size()) ? bus_log[base + i] : -1,
                      int'(v.ev[i]));
            end
        end
    endtask

    vec_t     vecs[8];
    vec_t     hv;
    bit [7:0] prev_rd;

    initial begin
        prev_rd = 8'h00;
        vecs[0] = mk(1'b0, 7'h50, 8'h12, 8'hA5, 8'h00, -1, prev_rd); prev_rd = vecs[0].exp_rd;
        vecs[1] = mk(1'b1, 7'h50, 8'h34, 8'h00, 8'h5C, -1, prev_rd); prev_rd = vecs[1].exp_rd;
        vecs[2] = mk(1'b0, 7'h50, 8'h56, 8'h11, 8'h00,  0, prev_rd); prev_rd = vecs[2].exp_rd;
        vecs[3] = mk(1'b1, 7'h21, 8'h9A, 8'h00, 8'hC3,  2, prev_rd); prev_rd = vecs[3].exp_rd;
        vecs[4] = mk(1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00,  2, prev_rd); prev_rd = vecs[4].exp_rd;
        for (int i = 5; i < 8; i++) begin
            int r;
            r = int'($urandom_range(0, 5));
            vecs[i] = mk(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                         8'($urandom), (r < 3) ? r : -1, prev_rd);
            prev_rd = vecs[i].exp_rd;
        end

        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("reset_scl", scl_o, 1);
        check("reset_sda_oe", sda_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_ack_err", ack_err, 0);
        check("reset_rd_data", rd_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_busy", busy, 0);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], -1, -1);

        // second request arrives mid-write and must be ignored
        hv = mk(1'b0, 7'h1B, 8'hC4, 8'h0F, 8'h00, -1, prev_rd);
        run_txn(hv, 900, -1);

        // reset lands in the REG byte; a fresh write then runs normally
        hv = mk(1'b0, 7'h2A, 8'h77, 8'h3C, 8'h00, -1, 8'h00);
        run_txn(hv, -1, 1600);
        hv = mk(1'b0, 7'h2A, 8'h77, 8'h3C, 8'h00, -1, 8'h00);
        run_txn(hv, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
